// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: pipeline and multicycle producers on one side,
// register-file write port and handshake/status outputs on the other.
interface wb_port_arbiter_if;
    logic        pipe_wb_en;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic        busy;

    modport slave (
        input  pipe_wb_en, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        output mc_ready, rf_we, rf_rd, rf_wd, stall_req, busy
    );

    modport master (
        output pipe_wb_en, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        input  mc_ready, rf_we, rf_rd, rf_wd, stall_req, busy
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single-port register-file writeback arbiter: pipeline has priority, a colliding
// multicycle result waits in a one-entry buffer and is forced out after STARVE_LIMIT losses.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      r_state;
    logic [4:0]  r_buf_rd;
    logic [31:0] r_buf_data;
    logic [2:0]  r_cnt;
    logic        r_rf_we;
    logic [4:0]  r_rf_rd;
    logic [31:0] r_rf_wd;

    logic        w_pipe_act;
    logic        w_mc_take;
    logic [3:0]  w_cnt_inc;

    assign w_pipe_act = bus.pipe_wb_en && (bus.pipe_rd != 5'd0);
    // mc_ready is only high in IDLE, so a valid offer there is an accept
    assign w_mc_take  = bus.mc_valid && bus.mc_ready && (bus.mc_rd != 5'd0);
    assign w_cnt_inc  = {1'b0, r_cnt} + 4'd1;

    assign bus.mc_ready  = (r_state == IDLE);
    assign bus.stall_req = (r_state == FORCE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_rd     = r_rf_rd;
    assign bus.rf_wd     = r_rf_wd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_buf_rd   <= 5'd0;
            r_buf_data <= 32'd0;
            r_cnt      <= 3'd0;
            r_rf_we    <= 1'b0;
            r_rf_rd    <= 5'd0;
            r_rf_wd    <= 32'd0;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pipe_act) begin
                        r_rf_we <= 1'b1;
                        r_rf_rd <= bus.pipe_rd;
                        r_rf_wd <= bus.pipe_data;
                        if (w_mc_take) begin
                            r_buf_rd   <= bus.mc_rd;
                            r_buf_data <= bus.mc_data;
                            r_cnt      <= 3'd0;
                            r_state    <= PEND;
                        end
                    end else if (w_mc_take) begin
                        r_rf_we <= 1'b1;
                        r_rf_rd <= bus.mc_rd;
                        r_rf_wd <= bus.mc_data;
                    end
                end
                PEND: begin
                    if (w_pipe_act) begin
                        r_rf_we <= 1'b1;
                        r_rf_rd <= bus.pipe_rd;
                        r_rf_wd <= bus.pipe_data;
                        r_cnt   <= w_cnt_inc[2:0];
                        if (w_cnt_inc == LIMIT) begin
                            r_state <= FORCE;
                        end
                    end else begin
                        r_rf_we <= 1'b1;
                        r_rf_rd <= r_buf_rd;
                        r_rf_wd <= r_buf_data;
                        r_cnt   <= 3'd0;
                        r_state <= IDLE;
                    end
                end
                FORCE: begin
                    // pipe is stalled this cycle and re-presents its write afterwards
                    r_rf_we <= 1'b1;
                    r_rf_rd <= r_buf_rd;
                    r_rf_wd <= r_buf_data;
                    r_cnt   <= 3'd0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed checking of wb_port_arbiter against a transaction-level
// model: a pending-result slot with a count of arbitration losses.
module tb_wb_port_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_trans  = 0;

    // reference model state
    bit          m_pending;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_losses;
    bit          m_must_drain;
    bit          e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_rd = '0; m_data = '0; m_losses = 0; m_must_drain = 0;
        e_we = 0; e_rd = '0; e_wd = '0;
    endtask

    // Decide who gets the single write port this cycle from the current inputs.
    task automatic model_step();
        bit pipe_wants = bus.pipe_wb_en && (bus.pipe_rd != 0);
        bit mc_offers  = bus.mc_valid && (bus.mc_rd != 0);
        e_we = 0;
        if (!m_pending) begin
            if (pipe_wants) begin
                e_we = 1; e_rd = bus.pipe_rd; e_wd = bus.pipe_data;
                if (mc_offers) begin
                    m_pending = 1; m_rd = bus.mc_rd; m_data = bus.mc_data; m_losses = 0;
                end
            end else if (mc_offers) begin
                e_we = 1; e_rd = bus.mc_rd; e_wd = bus.mc_data;
            end
        end else if (m_must_drain || !pipe_wants) begin
            e_we = 1; e_rd = m_rd; e_wd = m_data;
            m_pending = 0; m_must_drain = 0; m_losses = 0;
        end else begin
            e_we = 1; e_rd = bus.pipe_rd; e_wd = bus.pipe_data;
            m_losses++;
            if (m_losses == LIMIT) m_must_drain = 1;
        end
    endtask

    task automatic compare_all();
        check_eq("rf_we", 32'(bus.rf_we), 32'(e_we));
        check_eq("rf_rd", 32'(bus.rf_rd), 32'(e_rd));
        check_eq("rf_wd", bus.rf_wd, e_wd);
        check_eq("mc_ready", 32'(bus.mc_ready), 32'(!m_pending));
        check_eq("busy", 32'(bus.busy), 32'(m_pending));
        check_eq("stall_req", 32'(bus.stall_req), 32'(m_must_drain));
    endtask

    // Inputs are already driven (at a falling edge); clock once and compare.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        n_trans++;
        $display("txn %0d: pipe(%0b,%0d,%08h) mc(%0b,%0d,%08h) -> we=%0b rd=%0d wd=%08h busy=%0b stall=%0b",
                 n_trans, bus.pipe_wb_en, bus.pipe_rd, bus.pipe_data, bus.mc_valid, bus.mc_rd,
                 bus.mc_data, bus.rf_we, bus.rf_rd, bus.rf_wd, bus.busy, bus.stall_req);
    endtask

    task automatic set_in(input logic pe, input logic [4:0] prd, input logic [31:0] pd,
                          input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bus.pipe_wb_en = pe; bus.pipe_rd = prd; bus.pipe_data = pd;
        bus.mc_valid = mv; bus.mc_rd = mrd; bus.mc_data = md;
    endtask

    initial begin
        int stalls;
        int rd9_writes;
        int pipe_before;
        bit seen9;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // pipe only
        set_in(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        // bypass
        set_in(0, 0, 0, 1, 7, 32'h1234);
        step();
        // x0 filtering on both sources
        set_in(1, 0, 32'h77, 1, 0, 32'h99);
        step();
        check_eq("x0_no_write", 32'(bus.rf_we), 32'd0);

        // collision then starvation: pipe writes every cycle with a constant request
        set_in(1, 3, 32'hA, 1, 9, 32'hB);
        step();
        set_in(1, 12, 32'h55, 0, 0, 0);
        stalls = 0; rd9_writes = 0; pipe_before = 0; seen9 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            stalls += int'(bus.stall_req);
            if (bus.rf_we && bus.rf_rd == 5'd9) begin rd9_writes++; seen9 = 1; end
            else if (bus.rf_we && !seen9) pipe_before++;
        end
        check_eq("starve_stall_cycles", 32'(stalls), 32'd1);
        check_eq("starve_buf_writes", 32'(rd9_writes), 32'd1);
        check_eq("starve_pipe_first", 32'(pipe_before), 32'(LIMIT));

        // collision, pipe idle next: buffer drains on the following cycle
        set_in(1, 3, 32'hA, 1, 9, 32'hB);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        step();

        // reset while a result is buffered
        set_in(1, 3, 32'hA, 1, 9, 32'hB);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_eq("async_rst_we", 32'(bus.rf_we), 32'd0);
        check_eq("async_rst_rd", 32'(bus.rf_rd), 32'd0);
        check_eq("async_rst_wd", bus.rf_wd, 32'd0);
        check_eq("async_rst_ready", 32'(bus.mc_ready), 32'd1);
        check_eq("async_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd9_writes = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.rf_we && bus.rf_rd == 5'd9) rd9_writes++;
        end
        check_eq("rst_lost_buf", 32'(rd9_writes), 32'd0);

        // randomized traffic; a stalled pipe re-presents its previous request
        for (int i = 0; i < 400; i++) begin
            if (!m_must_drain) begin
                bus.pipe_wb_en = ($urandom_range(0, 3) != 0);
                bus.pipe_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.pipe_data  = $urandom;
            end
            bus.mc_valid = ($urandom_range(0, 1) == 1);
            bus.mc_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.mc_data  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, legal 1..7; consecutive lost arbitration cycles before a forced multicycle-unit write.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pipe_wb_en  input  1  pipeline writeback stage requests a register-file write.
REQ-005 pipe_rd  input  5  pipeline destination register.
REQ-006 pipe_data  input  32  pipeline write data.
REQ-007 mc_valid  input  1  multicycle unit (mul/div) offers a result.
REQ-008 mc_rd  input  5  multicycle destination register.
REQ-009 mc_data  input  32  multicycle result data.
REQ-010 mc_ready  output  1  arbiter accepts the multicycle result this cycle.
REQ-011 rf_we  output  1  registered register-file write enable.
REQ-012 rf_rd  output  5  registered register-file write address.
REQ-013 rf_wd  output  32  registered register-file write data.
REQ-014 stall_req  output  1  pipeline writeback stage holds its inputs unchanged next cycle.
REQ-015 busy  output  1  holding buffer occupied or force pending (state != IDLE).

Function
REQ-016 pipe_act = pipe_wb_en AND (pipe_rd != 0); mc_acc = mc_valid AND mc_ready.
REQ-017 One-entry holding buffer (rd 5b, data 32b) plus 3-bit starvation counter cnt.
REQ-018 FSM states: IDLE (buffer empty), PEND (buffer full, waiting), FORCE (buffer full, forced write).
REQ-019 mc_ready = 1 in IDLE only; 0 in PEND and FORCE (combinational from state).
REQ-020 stall_req = 1 in FORCE only (Moore output); busy = 1 in PEND and FORCE.
REQ-021 IDLE, pipe_act: pipe wins; rf_we<=1, rf_rd<=pipe_rd, rf_wd<=pipe_data.
REQ-022 IDLE, pipe_act and mc_acc with mc_rd != 0: capture mc_rd/mc_data into buffer, cnt<=0, go PEND.
REQ-023 IDLE, no pipe_act, mc_acc with mc_rd != 0: bypass; rf_we<=1, rf_rd<=mc_rd, rf_wd<=mc_data; stay IDLE.
REQ-024 IDLE, mc_acc with mc_rd == 0: result discarded, no write, no capture.
REQ-025 PEND, pipe_act: pipe wins (REQ-021 write); cnt<=cnt+1; if cnt+1 == STARVE_LIMIT go FORCE, else stay PEND.
REQ-026 PEND, no pipe_act: write buffer entry to rf_*; cnt<=0; go IDLE.
REQ-027 FORCE: write buffer entry to rf_* regardless of pipe inputs (pipe is stalled and re-presents them); cnt<=0; go IDLE.
REQ-028 No winner in a cycle: rf_we<=0; rf_rd and rf_wd hold previous values.
REQ-029 Write latency: one clock from winning input to rf_* outputs; at most one rf write per cycle.
REQ-030 WAW ordering between buffer and pipe is guaranteed upstream by the scoreboard; the arbiter performs no rd comparison.
REQ-031 Worst case: a buffered result is written within STARVE_LIMIT+1 cycles of capture.

Reset
REQ-032 reset asserted at any time (including mid-PEND/FORCE): state<=IDLE, buffer cleared (rd 0, data 0), cnt<=0, rf_we<=0, rf_rd<=0, rf_wd<=0; hence mc_ready=1, stall_req=0, busy=0; pending buffer content is lost.
REQ-033 First arbitration occurs on the first rising edge after reset deasserts.

Verification
REQ-034 Pipe only: pipe_wb_en=1, rd=5, data=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; mc_ready=1.
REQ-035 Bypass: IDLE, mc_valid=1, rd=7, data=0x1234, no pipe -> next cycle rf_we=1, rf_rd=7, rf_wd=0x1234; state stays IDLE.
REQ-036 Collision: pipe rd=3 data=0xA with mc rd=9 data=0xB -> cycle+1 writes rd3/0xA, busy=1, mc_ready=0; pipe idle next -> cycle+2 writes rd9/0xB, back to IDLE.
REQ-037 Starvation (STARVE_LIMIT=4): buffer holds rd9/0xB, pipe_act every cycle -> 4 pipe writes, then stall_req=1 for exactly one cycle, rd9/0xB written, then IDLE with cnt=0.
REQ-038 x0 filtering: mc_valid=1, mc_rd=0 -> no write, no capture, mc_ready stays 1; pipe_wb_en=1, pipe_rd=0 -> rf_we=0.
REQ-039 Reset while PEND with rd9 buffered -> all outputs zero immediately (asynchronous), mc_ready=1, rd9 never written.
